// File: rtl/float_expand_pkg.sv
// Shared definitions for the float front end.
// Contents:
//   float_flags_t    - classification flags that travel with an expanded value
//   get_exp_bias     - IEEE exponent bias for a given exponent width
//   clz_count_width  - width of a leading-zero count for a given input width
package float_expand_pkg;

  typedef struct packed {
    logic inf;
    logic nan;
    logic zero;
    logic denormal;
  } float_flags_t;

  // bias(E) = 2^(E-1) - 1
  function automatic int get_exp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // At least one bit, so a 1-bit input still yields a legal port
  function automatic int unsigned clz_count_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/float_expand_count_leading_zeros.sv
// Leading-zero counter.
// Ports:
//   in_i  [WIDTH-1:0]  value to scan
//   out_o [CNT_W-1:0]  number of zeros above the most significant 1
//                      (all-zero input returns 0)
module count_leading_zeros
  import float_expand_pkg::*;
#(
  parameter int unsigned WIDTH = 23
) (
  input  logic [WIDTH-1:0]                       in_i,
  output logic [clz_count_width(WIDTH)-1:0]      out_o
);

  localparam int unsigned CNT_W = clz_count_width(WIDTH);

  logic [CNT_W-1:0] count;
  logic             found;

  // Priority scan from the MSB; the first 1 seen fixes the count
  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!found && in_i[i]) begin
        count = CNT_W'(int'(WIDTH) - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign out_o = count;

endmodule

// File: rtl/float_expand.sv
// Widens an IEEE-style float (EXP_IN/FRAC_IN) to EXP_OUT/FRAC_OUT and
// classifies it for the downstream multiplier/adder.
// Configuration macro: FLOAT_EXPAND_REG_EN
//   undefined - purely combinational, zero latency (clock/reset unused)
//   defined   - value and flags registered on posedge clock, 1-cycle latency,
//               synchronous active-high reset clears them to +0 / no flags
// Ports:
//   clock, reset                               clock and sync active-high reset
//   in_sign_i, in_exponent_i, in_fraction_i    input float fields
//   out_sign_o, out_exponent_o, out_fraction_o expanded float fields
//   is_inf_o, is_nan_o, is_zero_o              input classification
//   is_denormal_o                              output encoding is denormal
module float_expand
  import float_expand_pkg::*;
#(
  parameter int unsigned EXP_IN   = 8,
  parameter int unsigned FRAC_IN  = 23,
  parameter int unsigned EXP_OUT  = 8,
  parameter int unsigned FRAC_OUT = 23
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_sign_i,
  input  logic [EXP_IN-1:0]   in_exponent_i,
  input  logic [FRAC_IN-1:0]  in_fraction_i,
  output logic                out_sign_o,
  output logic [EXP_OUT-1:0]  out_exponent_o,
  output logic [FRAC_OUT-1:0] out_fraction_o,
  output logic                is_inf_o,
  output logic                is_nan_o,
  output logic                is_zero_o,
  output logic                is_denormal_o
);

  localparam int          EXP_DELTA = get_exp_bias(EXP_OUT) - get_exp_bias(EXP_IN);
  localparam int unsigned PAD       = FRAC_OUT - FRAC_IN;
  localparam int unsigned CNT_W     = clz_count_width(FRAC_IN);
  localparam bit          WIDEN     = (EXP_OUT > EXP_IN);

  // Parameter sanity: renormalizing a denormal needs enough exponent headroom
  if (EXP_OUT < EXP_IN) begin : g_chk_exp
    $error("float_expand: EXP_OUT must be >= EXP_IN");
  end
  if (FRAC_OUT < FRAC_IN) begin : g_chk_frac
    $error("float_expand: FRAC_OUT must be >= FRAC_IN");
  end
  if (WIDEN && (EXP_DELTA <= int'(FRAC_IN) - 1)) begin : g_chk_range
    $error("float_expand: exponent range too small to renormalize denormals");
  end

  logic                exp_zero;
  logic                exp_ones;
  logic                frac_zero;
  logic [FRAC_OUT-1:0] frac_pad;
  logic [FRAC_OUT-1:0] nan_frac;
  logic [CNT_W-1:0]    lz;
  logic [CNT_W:0]      norm_shamt;

  logic                sign_d;
  logic [EXP_OUT-1:0]  exp_d;
  logic [FRAC_OUT-1:0] frac_d;
  float_flags_t        flags_d;

  assign exp_zero   = ~|in_exponent_i;
  assign exp_ones   = &in_exponent_i;
  assign frac_zero  = ~|in_fraction_i;
  assign frac_pad   = FRAC_OUT'(in_fraction_i) << PAD;
  // One extra bit so lz+1 cannot wrap when FRAC_IN is a power of two
  assign norm_shamt = (CNT_W + 1)'(lz) + (CNT_W + 1)'(1);

  count_leading_zeros #(
    .WIDTH (FRAC_IN)
  ) u_clz (
    .in_i  (in_fraction_i),
    .out_o (lz)
  );

  // Canonical quiet NaN fraction: MSB set, rest clear
  always_comb begin
    nan_frac               = '0;
    nan_frac[FRAC_OUT-1]   = 1'b1;
  end

  // Classification and field remapping
  always_comb begin
    sign_d  = in_sign_i;
    exp_d   = EXP_OUT'(in_exponent_i) + EXP_OUT'(EXP_DELTA);
    frac_d  = frac_pad;
    flags_d = '0;
    if (exp_ones) begin
      exp_d = '1;
      if (frac_zero) begin
        frac_d      = '0;
        flags_d.inf = 1'b1;
      end else begin
        sign_d      = 1'b0;
        frac_d      = nan_frac;
        flags_d.nan = 1'b1;
      end
    end else if (exp_zero) begin
      if (frac_zero) begin
        exp_d        = '0;
        frac_d       = '0;
        flags_d.zero = 1'b1;
      end else if (WIDEN) begin
        // Shift the leading 1 out of the field; it becomes the implicit bit
        frac_d = frac_pad << norm_shamt;
        exp_d  = EXP_OUT'(EXP_DELTA) - EXP_OUT'(lz);
      end else begin
        exp_d            = '0;
        flags_d.denormal = 1'b1;
      end
    end
  end

`ifdef FLOAT_EXPAND_REG_EN
  logic                sign_q;
  logic [EXP_OUT-1:0]  exp_q;
  logic [FRAC_OUT-1:0] frac_q;
  float_flags_t        flags_q;

  // Output stage; reset drops whatever value is in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      sign_q  <= 1'b0;
      exp_q   <= '0;
      frac_q  <= '0;
      flags_q <= '0;
    end else begin
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      frac_q  <= frac_d;
      flags_q <= flags_d;
    end
  end

  assign out_sign_o     = sign_q;
  assign out_exponent_o = exp_q;
  assign out_fraction_o = frac_q;
  assign is_inf_o       = flags_q.inf;
  assign is_nan_o       = flags_q.nan;
  assign is_zero_o      = flags_q.zero;
  assign is_denormal_o  = flags_q.denormal;
`else
  logic unused_clock_reset;
  assign unused_clock_reset = clock ^ reset;

  assign out_sign_o     = sign_d;
  assign out_exponent_o = exp_d;
  assign out_fraction_o = frac_d;
  assign is_inf_o       = flags_d.inf;
  assign is_nan_o       = flags_d.nan;
  assign is_zero_o      = flags_d.zero;
  assign is_denormal_o  = flags_d.denormal;
`endif

endmodule

// File: tb/tb_float_expand.sv
// Bench for float_expand: three instances (8/23->8/23, 5/10->8/23,
// 8/23->11/52), scoreboard of expected values, works with or without
// FLOAT_EXPAND_REG_EN.
module tb_float_expand;

`ifdef FLOAT_EXPAND_REG_EN
  localparam int unsigned LAT = 1;
`else
  localparam int unsigned LAT = 0;
`endif

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_INF  = 4'b1000;
  localparam logic [3:0] F_NAN  = 4'b0100;
  localparam logic [3:0] F_ZERO = 4'b0010;
  localparam logic [3:0] F_DEN  = 4'b0001;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [31:0] s_in = '0;
  logic [15:0] h_in = '0;
  logic [31:0] d_in = '0;

  logic        s_sign, h_sign, d_sign;
  logic [7:0]  s_exp, h_exp;
  logic [10:0] d_exp;
  logic [22:0] s_frac, h_frac;
  logic [51:0] d_frac;
  logic [3:0]  s_flags, h_flags, d_flags;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  sel;
    logic [63:0] out;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  float_expand #(.EXP_IN(8), .FRAC_IN(23), .EXP_OUT(8), .FRAC_OUT(23)) u_s (
    .clock(clock), .reset(reset),
    .in_sign_i(s_in[31]), .in_exponent_i(s_in[30:23]), .in_fraction_i(s_in[22:0]),
    .out_sign_o(s_sign), .out_exponent_o(s_exp), .out_fraction_o(s_frac),
    .is_inf_o(s_flags[3]), .is_nan_o(s_flags[2]), .is_zero_o(s_flags[1]),
    .is_denormal_o(s_flags[0])
  );

  float_expand #(.EXP_IN(5), .FRAC_IN(10), .EXP_OUT(8), .FRAC_OUT(23)) u_h (
    .clock(clock), .reset(reset),
    .in_sign_i(h_in[15]), .in_exponent_i(h_in[14:10]), .in_fraction_i(h_in[9:0]),
    .out_sign_o(h_sign), .out_exponent_o(h_exp), .out_fraction_o(h_frac),
    .is_inf_o(h_flags[3]), .is_nan_o(h_flags[2]), .is_zero_o(h_flags[1]),
    .is_denormal_o(h_flags[0])
  );

  float_expand #(.EXP_IN(8), .FRAC_IN(23), .EXP_OUT(11), .FRAC_OUT(52)) u_d (
    .clock(clock), .reset(reset),
    .in_sign_i(d_in[31]), .in_exponent_i(d_in[30:23]), .in_fraction_i(d_in[22:0]),
    .out_sign_o(d_sign), .out_exponent_o(d_exp), .out_fraction_o(d_frac),
    .is_inf_o(d_flags[3]), .is_nan_o(d_flags[2]), .is_zero_o(d_flags[1]),
    .is_denormal_o(d_flags[0])
  );

  // {flags, 64-bit value} of the selected instance
  function automatic logic [67:0] observe(input logic [1:0] sel);
    case (sel)
      2'd0:    return {s_flags, 32'h0, s_sign, s_exp, s_frac};
      2'd1:    return {h_flags, 32'h0, h_sign, h_exp, h_frac};
      default: return {d_flags, d_sign, d_exp, d_frac};
    endcase
  endfunction

  // Reference half -> single conversion, value-based (denormal = m * 2^-24)
  function automatic logic [35:0] half_model(input logic [15:0] h);
    logic [4:0]  e;
    logic [9:0]  m;
    logic [31:0] r;
    logic [3:0]  f;
    int          p;
    e = h[14:10];
    m = h[9:0];
    f = F_NONE;
    p = 0;
    if (e == 5'd31) begin
      if (m == 10'd0) begin r = {h[15], 8'hFF, 23'h0}; f = F_INF; end
      else begin r = 32'h7FC00000; f = F_NAN; end
    end else if (e == 5'd0) begin
      if (m == 10'd0) begin r = {h[15], 31'h0}; f = F_ZERO; end
      else begin
        for (int i = 0; i < 10; i++) if (m[i]) p = i;
        r = {h[15], 8'(p + 103), 23'((32'(m) << (23 - p)) & 32'h007FFFFF)};
      end
    end else begin
      r = {h[15], 8'(32'(e) + 32'd112), m, 13'h0};
    end
    return {f, r};
  endfunction

  task automatic drive(input logic [1:0] sel, input logic [31:0] val,
                       input logic [63:0] eo, input logic [3:0] ef);
    exp_t e;
    @(negedge clock);
    if (sel == 2'd0) s_in = val;
    else if (sel == 2'd1) h_in = val[15:0];
    else d_in = val;
    e.sel   = sel;
    e.out   = eo;
    e.flags = ef;
    sb.push_back(e);
  endtask

  task automatic settle();
    if (LAT != 0) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [67:0] got;
    @(negedge clock);
    reset = 1'b1;
    s_in  = 32'h3F800000;
    h_in  = 16'h3C00;
    d_in  = 32'h3F800000;
`ifdef FLOAT_EXPAND_REG_EN
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      got = observe(2'(k));
      total++;
      if (got[63:0] !== 64'h0) begin
        bad++;
        $display("FAIL reset_value inst=%0d got=%h want=0", k, got[63:0]);
      end
      total++;
      if (got[67:64] !== 4'h0) begin
        bad++;
        $display("FAIL reset_flags inst=%0d got=%b want=0000", k, got[67:64]);
      end
    end
`else
    #1;
    got = observe(2'd1);
    total++;
    if (got[63:0] !== 64'h3F800000 || got[67:64] !== F_NONE) begin
      bad++;
      $display("FAIL reset_ignored got=%h/%b want=3f800000/0000", got[63:0], got[67:64]);
    end
`endif
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_table(input logic [1:0] sel, input string name,
                           input logic [31:0] vin[], input logic [63:0] vout[],
                           input logic [3:0] vfl[]);
    exp_t        e;
    logic [67:0] got;
    for (int i = 0; i < vin.size(); i++) begin
      drive(sel, vin[i], vout[i], vfl[i]);
      settle();
      e   = sb.pop_front();
      got = observe(e.sel);
      total++;
      if (got[63:0] !== e.out) begin
        bad++;
        $display("FAIL %s_value in=%h got=%h want=%h", name, vin[i], got[63:0], e.out);
      end
      total++;
      if (got[67:64] !== e.flags) begin
        bad++;
        $display("FAIL %s_flags in=%h got=%b want=%b", name, vin[i], got[67:64], e.flags);
      end
    end
  endtask

  task automatic test_same_format();
    logic [31:0] vin[]  = '{32'h3F800000, 32'h00000001, 32'h007FFFFF, 32'h7F800000,
                            32'hFF812345, 32'h80000000, 32'hC0490FDB};
    logic [63:0] vout[] = '{64'h3F800000, 64'h00000001, 64'h007FFFFF, 64'h7F800000,
                            64'h7FC00000, 64'h80000000, 64'hC0490FDB};
    logic [3:0]  vfl[]  = '{F_NONE, F_DEN, F_DEN, F_INF, F_NAN, F_ZERO, F_NONE};
    run_table(2'd0, "same", vin, vout, vfl);
  endtask

  task automatic test_half_to_single();
    logic [31:0] vin[]  = '{32'h3C00, 32'hC000, 32'h0001, 32'h0200, 32'hFC00,
                            32'hFE01, 32'h8000, 32'h7BFF, 32'h03FF, 32'h0400};
    logic [63:0] vout[] = '{64'h3F800000, 64'hC0000000, 64'h33800000, 64'h38000000,
                            64'hFF800000, 64'h7FC00000, 64'h80000000, 64'h477FE000,
                            64'h387FC000, 64'h38800000};
    logic [3:0]  vfl[]  = '{F_NONE, F_NONE, F_NONE, F_NONE, F_INF, F_NAN, F_ZERO,
                            F_NONE, F_NONE, F_NONE};
    run_table(2'd1, "half", vin, vout, vfl);
  endtask

  task automatic test_single_to_double();
    logic [31:0] vin[]  = '{32'h3F800000, 32'h7F800001, 32'hFF800000, 32'h00000000,
                            32'h00000001, 32'h00400000};
    logic [63:0] vout[] = '{64'h3FF0000000000000, 64'h7FF8000000000000,
                            64'hFFF0000000000000, 64'h0000000000000000,
                            64'h36A0000000000000, 64'h3800000000000000};
    logic [3:0]  vfl[]  = '{F_NONE, F_NAN, F_INF, F_ZERO, F_NONE, F_NONE};
    run_table(2'd2, "double", vin, vout, vfl);
  endtask

  // Consecutive random halves, one per cycle, checked against the value model
  task automatic test_back_to_back();
    exp_t        e;
    logic [67:0] got;
    logic [15:0] h;
    logic [35:0] m;
    for (int i = 0; i < 40; i++) begin
      h = 16'($urandom_range(0, 65535));
      if (i % 3 == 0) h[14:10] = 5'd0;
      m = half_model(h);
      drive(2'd1, {16'h0, h}, {32'h0, m[31:0]}, m[35:32]);
      settle();
      e   = sb.pop_front();
      got = observe(e.sel);
      total++;
      if (got[63:0] !== e.out || got[67:64] !== e.flags) begin
        bad++;
        $display("FAIL b2b in=%h got=%h/%b want=%h/%b", h, got[63:0], got[67:64],
                 e.out, e.flags);
      end
    end
  endtask

  task automatic test_midstream_reset();
    exp_t        e;
    logic [67:0] got;
`ifdef FLOAT_EXPAND_REG_EN
    @(negedge clock);
    h_in  = 16'h3C00;
    reset = 1'b1;
    @(posedge clock);
    #1;
    got = observe(2'd1);
    total++;
    if (got !== 68'h0) begin
      bad++;
      $display("FAIL midstream_reset got=%h/%b want=0/0000", got[63:0], got[67:64]);
    end
    @(negedge clock);
    reset = 1'b0;
`endif
    drive(2'd1, 32'h4000, 64'h40000000, F_NONE);
    settle();
    e   = sb.pop_front();
    got = observe(e.sel);
    total++;
    if (got[63:0] !== e.out || got[67:64] !== e.flags) begin
      bad++;
      $display("FAIL after_reset got=%h/%b want=%h/%b", got[63:0], got[67:64],
               e.out, e.flags);
    end
  endtask

  initial begin
    test_reset();
    test_same_format();
    test_half_to_single();
    test_single_to_double();
    test_back_to_back();
    test_midstream_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
